// File: rtl/lifo_uart_pkg.sv
// Shared types and default sizing for the LIFO serial drain stage.
package lifo_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
endpackage

// File: rtl/lifo_uart_tx_bit_timer.sv
// Modulo-clks_per_bit counter; `last` marks the final cycle of each serial bit.
module bit_timer
  import lifo_uart_pkg::*;
#(
  parameter int clks_per_bit = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic last
);
  localparam int CW = $clog2(clks_per_bit);

  logic [CW-1:0] c_q, c_d;

  assign last = (c_q == CW'(clks_per_bit - 1));

  always_comb begin
    c_d = c_q + CW'(1);
    if (clr || last) c_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) c_q <= '0;
    else       c_q <= c_d;
  end
endmodule

// File: rtl/lifo_uart_tx.sv
// Pops the LIFO top whenever enabled and non-empty, and shifts it out as a
// start bit, data_width data bits LSB-first, and a stop bit.
module lifo_uart_tx
  import lifo_uart_pkg::*;
#(
  parameter int data_width   = DEF_DATA_WIDTH,
  parameter int clks_per_bit = DEF_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  empty,
  input  logic [data_width-1:0] r_data,
  output logic                  pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  done_tick
);
  localparam int NW = (data_width > 1) ? $clog2(data_width) : 1;

  tx_state_t             state_q, state_d;
  logic [data_width-1:0] b_q, b_d;
  logic [NW-1:0]         n_q, n_d;
  logic                  bit_last;
  logic                  timer_clr;

  bit_timer #(.clks_per_bit(clks_per_bit)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .last  (bit_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    n_d       = n_q;
    pop       = 1'b0;
    tx        = 1'b1;
    busy      = 1'b1;
    done_tick = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        // Hold the bit timer at zero so START gets a full bit period.
        timer_clr = 1'b1;
        if (en && !empty && !reset) begin
          pop     = 1'b1;
          b_d     = r_data;
          n_d     = '0;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_last) state_d = DATA;
      end
      DATA: begin
        tx = b_q[0];
        if (bit_last) begin
          b_d = b_q >> 1;
          if (n_q == NW'(data_width - 1)) begin
            n_d     = '0;
            state_d = STOP;
          end else begin
            n_d = n_q + NW'(1);
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          done_tick = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lifo_uart_tx.sv
// Bench: behavioural LIFO drives the DUT; a frame-level monitor checks every cycle.
module tb_lifo_uart_tx;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          empty;
  logic [DW-1:0] r_data;
  logic          pop, tx, busy, done_tick;

  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] mem [16];
  logic [4:0]    sp = '0;
  logic [3:0]    top;
  logic          full;

  int errors = 0;
  int checks = 0;
  logic          mon_on = 1'b0;
  int            pos = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [DW-1:0] fb = '0;
  logic [DW-1:0] sent [$];
  int            pop_cyc [$];

  lifo_uart_tx #(.data_width(DW), .clks_per_bit(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .empty     (empty),
    .r_data    (r_data),
    .pop       (pop),
    .tx        (tx),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  // Stack model standing in for lifo_buffer.
  assign top    = sp[3:0] - 4'd1;
  assign empty  = (sp == 5'd0);
  assign full   = (sp == 5'd16);
  assign r_data = (sp != 5'd0) ? mem[top] : '0;

  always @(posedge clk) begin
    if (clr_req) sp <= '0;
    else if (pop && push_req && sp != 5'd0) mem[top] <= push_data;
    else if (pop && sp != 5'd0) sp <= sp - 5'd1;
    else if (push_req && !full) begin
      mem[sp[3:0]] <= push_data;
      sp <= sp + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame-level reference: pos counts cycles since the pop (0 = idle).
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_on) begin
      check("pop", 32'(pop), 32'((pos == 0) && en && !empty && !reset));
      if (pos > 0) begin
        int idx;
        logic e_tx;
        idx  = (pos - 1) / CPB;
        e_tx = (idx == 0) ? 1'b0 : (idx == DW + 1) ? 1'b1 : fb[idx-1];
        check("tx_frame", 32'(tx), 32'(e_tx));
        check("busy_frame", 32'(busy), 32'd1);
        check("done_frame", 32'(done_tick), 32'(pos == FRAME));
      end else begin
        check("tx_idle", 32'(tx), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("done_idle", 32'(done_tick), 32'd0);
      end
    end
    if (done_tick === 1'b1) done_cnt++;
    if (reset) pos = 0;
    else if (pop === 1'b1) begin
      pos = 1;
      fb  = r_data;
      sent.push_back(r_data);
      pop_cyc.push_back(cyc);
    end else if (pos > 0) pos = (pos == FRAME) ? 0 : pos + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_req  = 1'b1;
    push_data = d;
    tick();
    push_req  = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    en      = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int budget);
    for (int i = 0; i < budget && sent.size() < target; i++) tick();
    check("wait_pop_timeout", 32'(sent.size() >= target), 32'd1);
  endtask

  initial begin
    int n0, d0;
    logic [DW-1:0] a, b, base;
    logic [DW-1:0] pushed [16];

    // Reset then idle with an empty stack and en high.
    reset = 1'b1; en = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    mon_on  = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (50) tick();

    // Two-entry LIFO order and frame spacing.
    do_reset();
    push(8'hB1); push(8'h1B);
    n0 = sent.size(); d0 = done_cnt;
    en = 1'b1;
    wait_sent(n0 + 2, 150);
    repeat (FRAME + 5) tick();
    check("s2_count", 32'(sent.size() - n0), 32'd2);
    if (sent.size() >= n0 + 2) begin
      check("s2_first", 32'(sent[n0]), 32'h1B);
      check("s2_second", 32'(sent[n0+1]), 32'hB1);
      check("s2_gap", 32'(pop_cyc[n0+1] - pop_cyc[n0]), 32'(FRAME + 1));
    end
    check("s2_empty", 32'(empty), 32'd1);
    check("s2_done", 32'(done_cnt - d0), 32'd2);

    // Full stack drain with random distinct bytes.
    do_reset();
    base = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      pushed[i] = base + 8'(i * 37);
      push(pushed[i]);
    end
    check("s3_full", 32'(full), 32'd1);
    n0 = sent.size(); d0 = done_cnt;
    en = 1'b1;
    wait_sent(n0 + 16, 16 * (FRAME + 1) + 50);
    repeat (FRAME + 5) tick();
    check("s3_count", 32'(sent.size() - n0), 32'd16);
    check("s3_done", 32'(done_cnt - d0), 32'd16);
    if (sent.size() >= n0 + 16) begin
      for (int i = 0; i < 16; i++) begin
        check("s3_order", 32'(sent[n0+i]), 32'(pushed[15-i]));
        if (i > 0) check("s3_gap", 32'(pop_cyc[n0+i] - pop_cyc[n0+i-1]), 32'(FRAME + 1));
      end
    end

    // en dropped mid-frame: frame completes, next pop waits for en.
    do_reset();
    a = 8'($urandom); b = 8'($urandom);
    push(a); push(b);
    n0 = sent.size(); d0 = done_cnt;
    en = 1'b1;
    wait_sent(n0 + 1, 10);
    repeat (10) tick();
    en = 1'b0;
    repeat (60) tick();
    check("s4_one_pop", 32'(sent.size() - n0), 32'd1);
    check("s4_done", 32'(done_cnt - d0), 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("s4_pop_on_en", 32'(pop), 32'd1);
    wait_sent(n0 + 2, 5);
    repeat (FRAME + 5) tick();
    if (sent.size() >= n0 + 2) check("s4_second", 32'(sent[n0+1]), 32'(a));

    // Reset during DATA bit 3 loses the in-flight byte.
    do_reset();
    a = 8'($urandom); b = 8'($urandom);
    push(a); push(b);
    n0 = sent.size(); d0 = done_cnt;
    en = 1'b1;
    wait_sent(n0 + 1, 10);
    repeat (CPB + 3 * CPB + 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("s5_tx", 32'(tx), 32'd1);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_trunc_done", 32'(done_cnt - d0), 32'd0);
    wait_sent(n0 + 2, 5);
    repeat (FRAME + 5) tick();
    if (sent.size() >= n0 + 2) begin
      check("s5_first", 32'(sent[n0]), 32'(b));
      check("s5_next", 32'(sent[n0+1]), 32'(a));
    end
    check("s5_done", 32'(done_cnt - d0), 32'd1);

    // Push while a frame is in DATA.
    do_reset();
    push(8'h0B);
    n0 = sent.size(); d0 = done_cnt;
    en = 1'b1;
    wait_sent(n0 + 1, 10);
    repeat (12) tick();
    push(8'h5A);
    wait_sent(n0 + 2, FRAME + 10);
    repeat (FRAME + 5) tick();
    if (sent.size() >= n0 + 2) begin
      check("s6_first", 32'(sent[n0]), 32'h0B);
      check("s6_second", 32'(sent[n0+1]), 32'h5A);
    end
    check("s6_done", 32'(done_cnt - d0), 32'd2);

    // Random pushes and en toggling; the monitor checks every cycle.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      push_req  = ($urandom_range(7) == 0);
      push_data = 8'($urandom);
      if ($urandom_range(31) == 0) en = ~en;
      tick();
    end
    push_req = 1'b0;
    en = 1'b1;
    repeat (16 * (FRAME + 1) + 10) tick();
    check("rnd_drained", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lifo_uart_tx.md
# lifo_uart_tx

Serial drain stage that sits directly downstream of `lifo_buffer`. Whenever the stack is non-empty and transmission is enabled, the block pops the top entry and shifts it out as an asynchronous serial frame: one start bit, `data_width` data bits LSB-first, and one stop bit. Stack contents therefore leave the chip in last-in-first-out order.

## Interface
- `data_width`, 8: frame payload width; must match the LIFO's `data_width`.
- `clks_per_bit`, 16: clock cycles per serial bit; legal range ≥ 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  permits starting a new frame; sampled only in IDLE.
- `empty`  in  1  from the LIFO's `empty`.
- `r_data`  in  `data_width`  from the LIFO's `r_data` (top of stack, combinational).
- `pop`  out  1  to the LIFO's `pop`; single-cycle strobe.
- `tx`  out  1  serial line; idle-high.
- `busy`  out  1  high from the cycle after `pop` through the last stop cycle.
- `done_tick`  out  1  one-cycle pulse in the final stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0.
  - If `en && !empty`, assert `pop`=1 combinationally in that cycle.
  - In the same edge, capture `r_data` into shift register `b_reg`, clear bit counter `c_reg` and bit index `n_reg`, and go to START.
- START: `tx`=0 for `clks_per_bit` cycles, then go to DATA.
- DATA: `tx`=`b_reg[0]`.
  - After `clks_per_bit` cycles, shift `b_reg` right by 1 and increment `n_reg`.
  - After bit `data_width-1`, go to STOP.
- STOP: `tx`=1 for `clks_per_bit` cycles.
  - `done_tick`=1 in the last cycle (`c_reg==clks_per_bit-1`).
  - Then return to IDLE.
- `c_reg` width: `$clog2(clks_per_bit)`. It counts 0..`clks_per_bit-1` and wraps to 0 on each bit boundary.
- `n_reg` width: `$clog2(data_width)`. It wraps only on the DATA→STOP transition.
- `pop` is never asserted outside IDLE and never while `empty`=1. An underflow pop is impossible by construction.
- `en` deasserted mid-frame does not abort the frame. It only blocks the next pop.
- Push into the LIFO while a frame is in flight does not disturb the frame, because the byte is already latched in `b_reg`.

## Timing
- Reset values:
  - state IDLE
  - `tx`=1, `pop`=0, `busy`=0, `done_tick`=0
  - `b_reg`=0, `c_reg`=0, `n_reg`=0
- Latency:
  - `pop` cycle to first start-bit cycle: 1 clock.
  - Frame length: `(data_width+2)*clks_per_bit` clocks after the `pop` cycle.
- Back-to-back frames: after STOP the FSM spends exactly one cycle in IDLE, during which `tx`=1 and the next `pop` fires.
  - Frame-to-frame period: `(data_width+2)*clks_per_bit + 1` clocks.
- `empty` rising in the same cycle the FSM reaches IDLE: no pop, and the FSM remains in IDLE.
- Reset mid-frame:
  - Next edge forces IDLE and `tx`=1.
  - The frame is truncated and the popped byte is lost; there is no re-push.
  - `pop` is suppressed while `reset`=1.

## Structure
- Package `lifo_uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
  - default constants `DEF_DATA_WIDTH`=8 and `DEF_CLKS_PER_BIT`=16
- One sub-module, `bit_timer`: parameterised modulo-`clks_per_bit` counter.
  - Input: synchronous clear.
  - Output: `last` flag, high when the count equals `clks_per_bit-1`.
  - The FSM uses `last` for all bit-boundary decisions.
- Integration: a top wrapper connects `lifo_buffer` and `lifo_uart_tx` via `pop`, `empty` and `r_data`.

## Test plan
All scenarios use `clks_per_bit`=4 and `data_width`=8.

- Reset then idle: hold `reset` for 2 cycles with `empty`=1 and `en`=1 → `tx`=1, `pop`=0, `busy`=0 for 50 cycles.
- Two-entry LIFO order: push 0xB1 then 0x1B, then raise `en`.
  - First frame, 4 cycles per bit: 0, 1,1,0,1,1,0,0,0, 1 (0x1B).
  - Second frame, starting exactly 41 clocks after the first `pop`: 0, 1,0,0,0,1,1,0,1, 1 (0xB1).
  - `empty`=1 after the second pop.
- Full stack drain: push 16 distinct bytes until `full`=1, then enable.
  - Expect 16 `pop` strobes spaced 41 cycles apart, 16 `done_tick` pulses, and bytes serialised in reverse push order.
- `en` gating: drop `en` 10 cycles into a frame.
  - The frame completes with `done_tick`=1.
  - No further `pop` while `en`=0.
  - The next pop occurs in the cycle `en` returns high.
- Reset mid-frame: assert `reset` during DATA bit 3.
  - Next cycle: `tx`=1, `busy`=0.
  - After release, the next frame carries the next LIFO entry, not the truncated byte.
- Concurrent push: push 0x5A while a frame of 0x0B is in DATA.
  - The 0x0B frame is unchanged.
  - The following frame carries 0x5A.
